// File: rtl/pilha_param.sv
// pilha_param: parametrised LIFO data stack between UC and ULA; `define PILHA_PEEK_EN adds the topo peek port.
// Latency: pop data lands on registered dout one cycle after the pop edge; no backpressure, misuse raises sticky overflow/underflow.
module pilha_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int ULA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         controle_pilha,
  input  logic [WIDTH-1:0]             din_UC,
  input  logic [ULA_WIDTH-1:0]         din_ULA,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
`ifdef PILHA_PEEK_EN
  ,
  output logic [WIDTH-1:0]             topo
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    mem_waddr;
  logic             mem_we;
  logic             ovf_set;
  logic             udf_set;
  logic             is_full;
  logic             is_empty;

  // Only the low WIDTH bits of the ALU word are stored; the rest is dropped.
  logic unused_ula;
  assign unused_ula = ^din_ULA;

  assign wdata    = controle_pilha ? din_ULA[WIDTH-1:0] : din_UC;
  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);
  assign top_idx  = AW'(count_q - ONE_C);
  assign push_idx = AW'(count_q);

  always_comb begin
    count_d   = count_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = push_idx;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;

    if (pop) begin
      if (is_empty) begin
        // Rejected pop; a simultaneous push still lands in slot 0.
        udf_set = 1'b1;
        if (push) begin
          mem_we    = 1'b1;
          mem_waddr = push_idx;
          count_d   = count_q + ONE_C;
        end
      end else begin
        dout_d = mem_q[top_idx];
        if (push) begin
          // Replace-top: old top is returned, new word takes its slot.
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
    end else if (push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = push_idx;
        count_d   = count_q + ONE_C;
      end
    end

    // A fresh error in the same cycle as clr_err keeps the flag set.
    overflow_d  = (overflow_q  & ~clr_err) | ovf_set;
    underflow_d = (underflow_q & ~clr_err) | udf_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a reset cycle only blocks the write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= wdata;
    end
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef PILHA_PEEK_EN
  assign topo = is_empty ? '0 : mem_q[top_idx];
`endif

endmodule

// File: tb/tb_pilha_param.sv
// Directed bench for pilha_param: vector table plus hand sequences for full/overflow and mid-sequence reset.
module tb_pilha_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        controle_pilha = 1'b0;
  logic [15:0] din_UC = '0;
  logic [31:0] din_ULA = '0;
  logic        clr_err = 1'b0;
  logic [15:0] dout;
  logic [4:0]  count;
  logic        full, empty, overflow, underflow;
`ifdef PILHA_PEEK_EN
  logic [15:0] topo;
`endif

  int checks = 0;
  int failures = 0;

  pilha_param #(.WIDTH(16), .DEPTH(16), .ULA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .pop            (pop),
    .controle_pilha (controle_pilha),
    .din_UC         (din_UC),
    .din_ULA        (din_ULA),
    .clr_err        (clr_err),
    .dout           (dout),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .underflow      (underflow)
`ifdef PILHA_PEEK_EN
    ,
    .topo           (topo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        push;
    logic        pop;
    logic        sel;
    logic        clr;
    logic [15:0] uc;
    logic [31:0] ula;
    logic [15:0] exp_dout;
    logic [4:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, input logic pu, input logic po, input logic s,
                              input logic c, input logic [15:0] uc, input logic [31:0] ula,
                              input logic [15:0] ed, input logic [4:0] ec,
                              input logic eo, input logic eu);
    vec_t v;
    v.rst_n = r; v.push = pu; v.pop = po; v.sel = s; v.clr = c;
    v.uc = uc; v.ula = ula; v.exp_dout = ed; v.exp_cnt = ec;
    v.exp_ovf = eo; v.exp_udf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pu, input logic po, input logic s,
                       input logic c, input logic [15:0] uc, input logic [31:0] ula);
    rst = r; push = pu; pop = po; controle_pilha = s; clr_err = c;
    din_UC = uc; din_ULA = ula;
    @(posedge clk);
    #1;
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [15:0] ed, input logic [4:0] ec,
                           input logic eo, input logic eu);
    chk({tag, ".dout"}, 32'(dout), 32'(ed));
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".full"}, 32'(full), 32'(ec == 5'd16));
    chk({tag, ".empty"}, 32'(empty), 32'(ec == 5'd0));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
  endtask

  initial begin
    //                r  pu po s  c  uc        ula            dout      cnt  ovf udf
    vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,32'h0,        16'h0000,5'd0,1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,16'h0001,32'h0,        16'h0000,5'd1,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,16'h0002,32'h0,        16'h0000,5'd2,1'b0,1'b0);
    vecs[3]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,16'h0003,32'h0,        16'h0000,5'd3,1'b0,1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h0003,5'd2,1'b0,1'b0);
    vecs[5]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h0002,5'd1,1'b0,1'b0);
    vecs[6]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h0001,5'd0,1'b0,1'b0);
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,16'h5555,32'hABCD_1234,16'h0001,5'd1,1'b0,1'b0);
    vecs[8]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h1234,5'd0,1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h1234,5'd0,1'b0,1'b1);
    vecs[10] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,16'h0055,32'h0,        16'h1234,5'd1,1'b0,1'b1);
    vecs[11] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0,        16'h1234,5'd1,1'b0,1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h0055,5'd0,1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,16'h0010,32'h0,        16'h0055,5'd1,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,16'h0020,32'h0,        16'h0055,5'd2,1'b0,1'b0);
    vecs[15] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,16'h0099,32'h0,        16'h0020,5'd2,1'b0,1'b0);
    vecs[16] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h0099,5'd1,1'b0,1'b0);
    vecs[17] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,        16'h0010,5'd0,1'b0,1'b0);
    vecs[18] = mk(1'b1,1'b0,1'b1,1'b0,1'b1,16'h0000,32'h0,        16'h0010,5'd0,1'b0,1'b1);
    vecs[19] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0,        16'h0010,5'd0,1'b0,1'b0);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst_n, vecs[i].push, vecs[i].pop, vecs[i].sel, vecs[i].clr,
            vecs[i].uc, vecs[i].ula);
      check_all($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_cnt,
                vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Fill to DEPTH, then exercise overflow and replace-top while full.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 32'h0);
    end
    check_all("fill16", 16'h0000, 5'd16, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0);
    check_all("ovf_push", 16'h0000, 5'd16, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA, 32'h0);
    check_all("replace_full", 16'h000F, 5'd16, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    check_all("pop_after_replace", 16'h00AA, 5'd15, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    check_all("pop_14", 16'h000E, 5'd14, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0);
    check_all("clr_ovf", 16'h000E, 5'd14, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0456, 32'h0);
    check_all("refill16", 16'h000E, 5'd16, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0789, 32'h0);
    check_all("ovf_beats_clr", 16'h000E, 5'd16, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    check_all("pop_top_kept", 16'h0456, 5'd15, 1'b1, 1'b0);

    // Mid-sequence reset with a push pending.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 32'h0);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 32'h0);
    check_all("pre_reset", 16'h0005, 5'd5, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077, 32'h0);
    check_all("reset_mid", 16'h0000, 5'd0, 1'b0, 1'b0);

`ifdef PILHA_PEEK_EN
    chk("topo_after_reset", 32'(topo), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 32'h0);
    chk("topo_push7", 32'(topo), 32'h0007);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pilha_param.md
Name: pilha_param

Overview:
- Parametrised successor of the processor's 16x16 data stack.
- Sits between the control unit (UC) and the ALU (ULA). Stores operands pushed from either source and returns popped values on a registered output.
- Adds generic width and depth, occupancy count, full/empty flags, and sticky overflow/underflow errors.
- Adds defined simultaneous push+pop (replace-top) behaviour.

Parameters:
- WIDTH, 16: stack word width in bits.
- DEPTH, 16: number of entries; any integer ≥ 2, not required to be a power of two.
- ULA_WIDTH, 32: width of the ALU data input; must be ≥ WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- push  input  1  write request for this cycle.
- pop  input  1  read/remove request for this cycle.
- controle_pilha  input  1  push source select: 0 = din_UC, 1 = din_ULA.
- din_UC  input  WIDTH  data from control unit.
- din_ULA  input  ULA_WIDTH  data from ALU; low WIDTH bits are stored.
- clr_err  input  1  clears the sticky error flags.
- dout  output  WIDTH  registered value of the last successful pop.
- count  output  $clog2(DEPTH+1)  current number of entries.
- full  output  1  count == DEPTH (combinational from count).
- empty  output  1  count == 0 (combinational from count).
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: rst sampled low at a rising edge forces count=0, dout=0, overflow=0, underflow=0. Memory contents are not cleared. Reset overrides push, pop and clr_err in the same cycle, including mid-sequence.
- Data in: wdata = controle_pilha ? din_ULA[WIDTH-1:0] : din_UC. Upper ALU bits are discarded, not saturated.
- Push only, not full: mem[count] <= wdata; count += 1. dout unchanged.
- Pop only, not empty: dout <= mem[count-1]; count -= 1. Latency: value visible on dout one cycle after the pop edge.
- Push+pop, not empty (replace-top): dout <= old mem[count-1]; mem[count-1] <= wdata; count unchanged. Valid when full.
- Push+pop, empty: the pop is rejected and sets underflow; the push completes (count 0→1); dout unchanged.
- Push while full, no pop: ignored; memory and count unchanged; overflow <= 1.
- Pop while empty, no push: ignored; dout holds its last value; underflow <= 1.
- clr_err=1: overflow and underflow <= 0. A new error event in the same cycle wins, so the flag is set.
- Idle (push=pop=0): no state change.
- count never wraps; it is bounded to 0..DEPTH.

Optional Feature:
- Macro: PILHA_PEEK_EN.
- Defined: adds output port topo [WIDTH-1:0], a combinational view of mem[count-1].
  - topo = 0 when empty.
  - topo updates in the same cycle the push/pop edge changes count or the top entry.
- Undefined: topo port and its read mux are absent; all other behaviour is identical.

Test Plan:
- Reset, then push din_UC=16'h0001, 16'h0002, 16'h0003 with controle_pilha=0, then pop three times -> dout sequence 3, 2, 1 (each one cycle after its pop); count 3→0; empty=1 at end.
- controle_pilha=1, din_ULA=32'hABCD_1234, push then pop -> dout=16'h1234; din_UC ignored.
- Push 16 values 0..15, then push 16'hFFFF -> full=1, count=16, overflow=1. Pop -> dout=15. Assert clr_err -> overflow=0.
- From reset, pop -> underflow=1, dout=0, count=0. Same cycle push+pop with din_UC=16'h0055 -> count=1, dout unchanged, underflow stays 1.
- Stack holds 16'h0010, 16'h0020; push+pop with din_UC=16'h0099 -> dout=16'h0020, count=2. Next pop -> dout=16'h0099.
- Push 5 entries, drive rst=0 for one cycle while push=1 -> count=0, dout=0, flags 0. With PILHA_PEEK_EN defined, topo=0 after reset and topo=16'h0007 after one push of 7.
